// File: rtl/ram_march_bist.sv
// March C- BIST engine: walks the RAM through six march elements and reports pass/fail.
// Define BIST_STOP_ON_FAIL_EN to halt on the first mismatch instead of running to completion.
module ram_march_bist #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [7:0]        err_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   // Element index 6 marks "every op issued"; the next RUN cycle moves to FLUSH.
   localparam logic [2:0] ELEM_END = 3'd6;

   state_t            state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              ph_q, ph_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rdPend_q, rdPend_d;
   logic [DATA_W-1:0] rdExp_q, rdExp_d;
   logic              cmpValid_q, cmpValid_d;
   logic [DATA_W-1:0] cmpExp_q, cmpExp_d;
   logic [ADDR_W-1:0] cmpAddr_q, cmpAddr_d;
   logic [7:0]        errCnt_q, errCnt_d;
   logic [ADDR_W-1:0] failAddr_q, failAddr_d;
   logic [DATA_W-1:0] failData_q, failData_d;

   logic              descending, lastPhase, atLastAddr, opIsWrite;
   logic              wrOnes, rdOnes, mismatch, issue;
   logic [2:0]        nextElem;
   logic [ADDR_W-1:0] lastAddr;

   assign descending = (elem_q >= 3'd3);
   assign lastPhase  = (elem_q == 3'd0) || (elem_q == 3'd5) || ph_q;
   assign lastAddr   = descending ? '0 : '1;
   assign atLastAddr = (ptr_q == lastAddr);
   assign opIsWrite  = (elem_q == 3'd0) || ph_q;
   assign wrOnes     = (elem_q == 3'd1) || (elem_q == 3'd3);
   assign rdOnes     = (elem_q == 3'd2) || (elem_q == 3'd4);
   assign nextElem   = elem_q + 3'd1;
   assign mismatch   = cmpValid_q && (ram_rdata != cmpExp_q);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         elem_q     <= '0;
         ptr_q      <= '0;
         ph_q       <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         rdPend_q   <= 1'b0;
         rdExp_q    <= '0;
         cmpValid_q <= 1'b0;
         cmpExp_q   <= '0;
         cmpAddr_q  <= '0;
         errCnt_q   <= '0;
         failAddr_q <= '0;
         failData_q <= '0;
      end else begin
         state_q    <= state_d;
         elem_q     <= elem_d;
         ptr_q      <= ptr_d;
         ph_q       <= ph_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         rdPend_q   <= rdPend_d;
         rdExp_q    <= rdExp_d;
         cmpValid_q <= cmpValid_d;
         cmpExp_q   <= cmpExp_d;
         cmpAddr_q  <= cmpAddr_d;
         errCnt_q   <= errCnt_d;
         failAddr_q <= failAddr_d;
         failData_q <= failData_d;
      end
   end

   // The pointer (elem/ptr/ph) names the next op to issue and sits at zero outside RUN,
   // so a start from IDLE or DONE issues w0 @ 0 on the very same edge.
   always_comb begin
      state_d    = state_q;
      elem_d     = '0;
      ptr_d      = '0;
      ph_d       = 1'b0;
      addr_d     = addr_q;
      we_d       = 1'b0;
      wdata_d    = '0;
      rdPend_d   = 1'b0;
      rdExp_d    = '0;
      cmpExp_d   = rdExp_q;
      cmpAddr_d  = addr_q;
      errCnt_d   = errCnt_q;
      failAddr_d = failAddr_q;
      failData_d = failData_q;
      issue      = 1'b0;

      if (mismatch) begin
         if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
         if (errCnt_q == 8'd0) begin
            failAddr_d = cmpAddr_q;
            failData_d = ram_rdata;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               issue      = 1'b1;
               errCnt_d   = '0;
               failAddr_d = '0;
               failData_d = '0;
            end
         end
         RUN: begin
            if (elem_q == ELEM_END) state_d = FLUSH;
            else                    issue   = 1'b1;
         end
         FLUSH: state_d = DONE;
         default: state_d = IDLE;
      endcase

`ifdef BIST_STOP_ON_FAIL_EN
      if (mismatch) begin
         issue   = 1'b0;
         state_d = DONE;
      end
`endif

      if (issue) begin
         state_d  = RUN;
         addr_d   = ptr_q;
         we_d     = opIsWrite;
         wdata_d  = (opIsWrite && wrOnes) ? '1 : '0;
         rdPend_d = !opIsWrite;
         rdExp_d  = rdOnes ? '1 : '0;
         if (!lastPhase) begin
            elem_d = elem_q;
            ptr_d  = ptr_q;
            ph_d   = 1'b1;
         end else if (!atLastAddr) begin
            elem_d = elem_q;
            ptr_d  = descending ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
         end else begin
            elem_d = nextElem;
            ptr_d  = (nextElem >= 3'd3) ? '1 : '0;
         end
      end

      cmpValid_d = rdPend_q && ((state_d == RUN) || (state_d == FLUSH));
   end

   assign ram_addr  = addr_q;
   assign ram_we    = we_q;
   assign ram_wdata = wdata_q;
   assign busy      = (state_q == RUN) || (state_q == FLUSH);
   assign done      = (state_q == DONE);
   assign pass      = (state_q == DONE) && (errCnt_q == 8'd0);
   assign fail_addr = failAddr_q;
   assign fail_data = failData_q;
   assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Testbench for ram_march_bist: a fault-injecting RAM model plus a March C- reference built from loops.
module tb_ram_march_bist;

   localparam int AW   = 6;
   localparam int DW   = 8;
   localparam int N    = 1 << AW;
   localparam int NOPS = 10 * N;

`ifdef BIST_STOP_ON_FAIL_EN
   localparam bit STOP_MODE = 1'b1;
`else
   localparam bit STOP_MODE = 1'b0;
`endif

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
   } op_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] ramAddr;
   logic          ramWe;
   logic [DW-1:0] ramWdata;
   logic [DW-1:0] ramRdata;
   logic          busy, done, pass;
   logic [AW-1:0] failAddr;
   logic [DW-1:0] failData;
   logic [7:0]    errCnt;

   logic [DW-1:0] mem [N];
   int            faultAddr = -1;
   logic [DW-1:0] stuck0    = '0;
   logic [DW-1:0] stuck1    = '0;
   bit            alwaysBad = 1'b0;

   op_t           expOps[$];
   int            mErr, mFailAddr, mFailData, mStop, mDoneCyc;
   int            checks   = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   ram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_in   (clk),
      .reset    (rst),
      .start    (start),
      .ram_addr (ramAddr),
      .ram_we   (ramWe),
      .ram_wdata(ramWdata),
      .ram_rdata(ramRdata),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .fail_addr(failAddr),
      .fail_data(failData),
      .err_cnt  (errCnt)
   );

   // Injected faults act on the read path only, so stored data stays the written value.
   function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] d);
      if (alwaysBad) return ~d;
      if (a == faultAddr) return (d & ~stuck0) | stuck1;
      return d;
   endfunction

   // Synchronous RAM: read data appears the cycle after the address is presented.
   always @(posedge clk) begin
      if (ramWe) mem[ramAddr] <= ramWdata;
      ramRdata <= faulty(int'(ramAddr), mem[ramAddr]);
   end

   // Op codes: 0=w0 1=w1 2=r0 3=r1.
   function automatic int opCode(input int e, input int p);
      case (e)
         0:       return 0;
         1, 3:    return (p == 0) ? 2 : 1;
         2, 4:    return (p == 0) ? 3 : 0;
         default: return 2;
      endcase
   endfunction

   // Walks March C- over an abstract memory with the injected fault and records the op
   // stream, the mismatch statistics and when the engine should report done.
   function automatic void buildModel();
      logic [DW-1:0] m [N];
      logic [DW-1:0] expv, got;
      int a, code, len, idx, keep;
      expOps.delete();
      mErr = 0; mFailAddr = 0; mFailData = 0; mStop = -1;
      for (int i = 0; i < N; i++) m[i] = '0;
      idx = 0;
      for (int e = 0; e < 6; e++) begin
         len = (e == 0 || e == 5) ? 1 : 2;
         for (int i = 0; i < N; i++) begin
            a = (e < 3) ? i : N - 1 - i;
            for (int p = 0; p < len; p++) begin
               code = opCode(e, p);
               if (code < 2) begin
                  m[a] = (code == 1) ? '1 : '0;
                  expOps.push_back('{1'b1, AW'(a), m[a]});
               end else begin
                  expOps.push_back('{1'b0, AW'(a), '0});
                  expv = (code == 3) ? '1 : '0;
                  got  = faulty(a, m[a]);
                  if (got != expv) begin
                     if (mErr == 0) begin
                        mFailAddr = a;
                        mFailData = int'(got);
                     end
                     if (mErr < 255) mErr++;
                     if (STOP_MODE && mStop < 0) mStop = idx;
                  end
               end
               idx++;
            end
         end
      end
      if (mStop >= 0) begin
         keep = (mStop + 2 < NOPS) ? mStop + 2 : NOPS;
         while (expOps.size() > keep) void'(expOps.pop_back());
         mDoneCyc = mStop + 3;
      end else begin
         mDoneCyc = NOPS + 2;
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic waitDone(output int doneCyc);
      doneCyc = -1;
      for (int c = 1; c <= NOPS + 20; c++) begin
         @(negedge clk);
         if (done) begin
            doneCyc = c;
            break;
         end
      end
   endtask

   // One start pulse, then the op stream, completion time and result registers are checked.
   task automatic applyStimulus(input string tag);
      int cyc, nOps, badOps, doneCyc, busyAfter;
      buildModel();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0; nOps = 0; badOps = 0; doneCyc = -1;
      while (doneCyc < 0 && cyc < NOPS + 20) begin
         @(negedge clk);
         cyc++;
         if (done) doneCyc = cyc;
         else if (busy && cyc <= NOPS) begin
            if (nOps >= expOps.size()) badOps++;
            else if (ramWe !== expOps[nOps].we || ramAddr !== expOps[nOps].addr ||
                     ramWdata !== expOps[nOps].wd) badOps++;
            nOps++;
         end
      end
      checkOutput({tag, ".opCount"}, 32'(nOps), 32'(expOps.size()));
      checkOutput({tag, ".opBad"}, 32'(badOps), 32'd0);
      checkOutput({tag, ".doneCycle"}, 32'(doneCyc), 32'(mDoneCyc));
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".pass"}, 32'(pass), (mErr == 0) ? 32'd1 : 32'd0);
      checkOutput({tag, ".errCnt"}, 32'(errCnt), 32'(mErr));
      checkOutput({tag, ".failAddr"}, 32'(failAddr), 32'(mFailAddr));
      checkOutput({tag, ".failData"}, 32'(failData), 32'(mFailData));
      busyAfter = 0;
      repeat (4) begin
         @(negedge clk);
         if (ramWe || busy || !done) busyAfter++;
      end
      checkOutput({tag, ".quietInDone"}, 32'(busyAfter), 32'd0);
   endtask

   task automatic clearFault();
      faultAddr = -1;
      stuck0    = '0;
      stuck1    = '0;
      alwaysBad = 1'b0;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int doneCyc, b;
      for (int i = 0; i < N; i++) mem[i] = '0;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset.ramAddr", 32'(ramAddr), 32'd0);
      checkOutput("reset.ramWe", 32'(ramWe), 32'd0);
      checkOutput("reset.ramWdata", 32'(ramWdata), 32'd0);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.pass", 32'(pass), 32'd0);
      checkOutput("reset.failAddr", 32'(failAddr), 32'd0);
      checkOutput("reset.failData", 32'(failData), 32'd0);
      checkOutput("reset.errCnt", 32'(errCnt), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      clearFault();
      applyStimulus("clean");

      faultAddr = 5;
      stuck0    = 8'h08;
      applyStimulus("sa0bit3addr5");

      clearFault();
      alwaysBad = 1'b1;
      applyStimulus("alwaysBad");

      for (int t = 0; t < 4; t++) begin
         clearFault();
         faultAddr = int'($urandom_range(0, N - 1));
         b         = int'($urandom_range(0, DW - 1));
         if ($urandom_range(0, 1) == 1) stuck1 = DW'(1) << b;
         else                           stuck0 = DW'(1) << b;
         applyStimulus($sformatf("rand%0d", t));
      end

      // Reset in cycle 50 lands on an E0 write, so ram_we must fall without a clock edge.
      clearFault();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (50) @(negedge clk);
      checkOutput("midRun.weBefore", 32'(ramWe), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midRun.ramWe", 32'(ramWe), 32'd0);
      checkOutput("midRun.busy", 32'(busy), 32'd0);
      checkOutput("midRun.ramAddr", 32'(ramAddr), 32'd0);
      checkOutput("midRun.errCnt", 32'(errCnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus("afterReset");

      // Start held high: a second run must begin the cycle after done rises.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      waitDone(doneCyc);
      checkOutput("held.firstDone", 32'(doneCyc), 32'(NOPS + 2));
      @(negedge clk);
      checkOutput("held.busyAgain", 32'(busy), 32'd1);
      checkOutput("held.doneDropped", 32'(done), 32'd0);
      checkOutput("held.firstOpWe", 32'(ramWe), 32'd1);
      checkOutput("held.firstOpAddr", 32'(ramAddr), 32'd0);
      start = 1'b0;
      waitDone(doneCyc);
      checkOutput("held.secondDone", (doneCyc > 0) ? 32'd1 : 32'd0, 32'd1);
      checkOutput("held.secondPass", 32'(pass), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
